// File: rtl/vga_types.sv
// rtl/vga_types.sv - shared pixel and arbiter state types for the VGA framebuffer path
package vga_types;

    localparam int FB_PIX_W = 12;

    // Packed {r, g, b}, 4 bits per channel.
    typedef logic [FB_PIX_W-1:0] fb_pix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - host pixel-write port of the framebuffer arbiter
interface vga_fb_arbiter_if #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int PIX_W  = 12
) ();

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    logic             i_wr_valid;
    logic             o_wr_ready;
    logic [XW-1:0]    i_wr_x;
    logic [YW-1:0]    i_wr_y;
    logic [PIX_W-1:0] i_wr_data;

    modport master (
        output i_wr_valid, i_wr_x, i_wr_y, i_wr_data,
        input  o_wr_ready
    );

    modport slave (
        input  i_wr_valid, i_wr_x, i_wr_y, i_wr_data,
        output o_wr_ready
    );

endinterface

// File: rtl/vga_fb_addr_gen.sv
// rtl/vga_fb_addr_gen.sv - registered row*WIDTH + col address generator with row latch and column counter
module vga_fb_addr_gen #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    localparam int XW     = $clog2(WIDTH),
    localparam int YW     = $clog2(HEIGHT),
    localparam int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [YW-1:0]     i_load_row,
    input  logic [XW-1:0]     i_load_col,
    input  logic              i_step,
    output logic [XW-1:0]     o_col,
    output logic [ADDR_W-1:0] o_addr
);

    logic [YW-1:0]     row_d, row_q;
    logic [XW-1:0]     col_d, col_q;
    logic [ADDR_W-1:0] addr_d, addr_q;

    // Load wins over step; the address is formed from the next row/col so it lines up with them.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (i_load) begin
            row_d = i_load_row;
            col_d = i_load_col;
        end else if (i_step) begin
            col_d = col_q + XW'(1);
        end
        addr_d = ADDR_W'(row_d) * ADDR_W'(WIDTH) + ADDR_W'(col_d);
    end

    // Row, column and address registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
        end
    end

    assign o_col  = col_q;
    assign o_addr = addr_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port framebuffer arbiter: line prefetch into ping-pong buffer over host writes
module vga_fb_arbiter
    import vga_types::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int PIX_W  = 12,
    localparam int XW     = $clog2(WIDTH),
    localparam int YW     = $clog2(HEIGHT),
    localparam int ADDR_W = $clog2(WIDTH * HEIGHT)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_new_line,
    input  logic              i_fill_en,
    input  logic [YW-1:0]     i_fill_row,
    vga_fb_arbiter_if.slave   wr,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [PIX_W-1:0]  o_ram_wdata,
    input  logic [PIX_W-1:0]  i_ram_rdata,
    output logic              o_lb_we,
    output logic              o_lb_bank,
    output logic [XW-1:0]     o_lb_addr,
    output logic [PIX_W-1:0]  o_lb_data,
    output logic              o_busy,
    output logic              o_underrun
);

    arb_state_t state_d, state_q;

    logic             request;
    logic             last_col;
    logic             wr_ready;
    logic             accept;

    logic             gen_load;
    logic [YW-1:0]    gen_load_row;
    logic [XW-1:0]    gen_load_col;
    logic             gen_step;
    logic [XW-1:0]    gen_col;

    logic             ram_en_d, ram_en_q;
    logic             ram_we_d, ram_we_q;
    logic [PIX_W-1:0] ram_wdata_d, ram_wdata_q;
    logic             fill_bank_d, fill_bank_q;
    logic             lb_we_d, lb_we_q;
    logic [XW-1:0]    lb_addr_d, lb_addr_q;
    logic             lb_bank_d, lb_bank_q;
    logic             underrun_d, underrun_q;

    assign request  = i_new_line & i_fill_en;
    assign last_col = (gen_col == XW'(WIDTH - 1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a fill request restarts FILL from any state.
    always_comb begin
        state_d = state_q;
        if (request) begin
            state_d = FILL;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                FILL:    state_d = last_col ? DRAIN : FILL;
                DRAIN:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: host handshake, address generator control and next values of the registered strobes.
    always_comb begin
        wr_ready     = (state_q == IDLE) & ~request & ~i_rst;
        accept       = wr.i_wr_valid & wr_ready;

        gen_load     = request | accept;
        gen_load_row = request ? i_fill_row : wr.i_wr_y;
        gen_load_col = request ? '0 : wr.i_wr_x;
        gen_step     = (state_q == FILL) & ~last_col & ~request;

        ram_en_d     = accept | (state_d == FILL);
        ram_we_d     = accept;
        ram_wdata_d  = accept ? wr.i_wr_data : ram_wdata_q;

        fill_bank_d  = fill_bank_q ^ request;
        underrun_d   = underrun_q | (request & (state_q != IDLE));

        // The read on the bus this cycle lands next cycle, tagged with the bank it was issued for.
        lb_we_d      = ram_en_q & ~ram_we_q;
        lb_addr_d    = gen_col;
        lb_bank_d    = fill_bank_q;
    end

    // Registered RAM and line-buffer outputs plus bank and underrun state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            fill_bank_q <= 1'b0;
            underrun_q  <= 1'b0;
            lb_we_q     <= 1'b0;
            lb_addr_q   <= '0;
            lb_bank_q   <= 1'b0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            fill_bank_q <= fill_bank_d;
            underrun_q  <= underrun_d;
            lb_we_q     <= lb_we_d;
            lb_addr_q   <= lb_addr_d;
            lb_bank_q   <= lb_bank_d;
        end
    end

    vga_fb_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_addr_gen (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (gen_load),
        .i_load_row (gen_load_row),
        .i_load_col (gen_load_col),
        .i_step     (gen_step),
        .o_col      (gen_col),
        .o_addr     (o_ram_addr)
    );

    assign wr.o_wr_ready = wr_ready;
    assign o_ram_en      = ram_en_q;
    assign o_ram_we      = ram_we_q;
    assign o_ram_wdata   = ram_wdata_q;
    assign o_lb_we       = lb_we_q;
    assign o_lb_addr     = lb_addr_q;
    assign o_lb_bank     = lb_bank_q;
    assign o_lb_data     = i_ram_rdata;
    assign o_busy        = (state_q != IDLE);
    assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
    import vga_types::*;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int PW = 12;
    localparam int XW = 3;
    localparam int YW = 2;
    localparam int AW = 5;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          new_line = 1'b0;
    logic          fill_en  = 1'b0;
    logic [YW-1:0] fill_row = '0;

    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    fb_pix_t       ram_wdata;
    fb_pix_t       ram_rdata = '0;
    logic          lb_we;
    logic          lb_bank;
    logic [XW-1:0] lb_addr;
    fb_pix_t       lb_data;
    logic          busy;
    logic          underrun;

    int n_checks = 0;
    int n_fail   = 0;

    vga_fb_arbiter_if #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) wr_if ();

    vga_fb_arbiter #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_new_line  (new_line),
        .i_fill_en   (fill_en),
        .i_fill_row  (fill_row),
        .wr          (wr_if),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_lb_we     (lb_we),
        .o_lb_bank   (lb_bank),
        .o_lb_addr   (lb_addr),
        .o_lb_data   (lb_data),
        .o_busy      (busy),
        .o_underrun  (underrun)
    );

    always #5 clk = ~clk;

    // RAM model: read data is the address, one cycle after the read strobe.
    always @(posedge clk) begin
        if (ram_en && !ram_we) ram_rdata <= fb_pix_t'(ram_addr);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        wr_if.i_wr_valid = 1'b0;
        wr_if.i_wr_x     = '0;
        wr_if.i_wr_y     = '0;
        wr_if.i_wr_data  = '0;

        // Reset cycles.
        @(negedge clk);
        @(negedge clk); #1;
        check("rst_wr_ready", wr_if.o_wr_ready, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_lb_we", lb_we, 0);

        // First cycle after reset falls.
        @(negedge clk); rst = 1'b0; #1;
        check("idle_wr_ready", wr_if.o_wr_ready, 1);
        check("idle_ram_en", ram_en, 0);
        check("idle_lb_we", lb_we, 0);
        check("idle_lb_bank", lb_bank, 0);
        check("idle_busy", busy, 0);
        check("idle_underrun", underrun, 0);

        // Host write x=3 y=2.
        @(negedge clk);
        wr_if.i_wr_valid = 1'b1; wr_if.i_wr_x = 3'd3; wr_if.i_wr_y = 2'd2; wr_if.i_wr_data = 12'hABC; #1;
        check("hw_ready", wr_if.o_wr_ready, 1);
        @(negedge clk); wr_if.i_wr_valid = 1'b0; #1;
        check("hw_ram_en", ram_en, 1);
        check("hw_ram_we", ram_we, 1);
        check("hw_addr", ram_addr, 19);
        check("hw_wdata", ram_wdata, 12'hABC);

        // new_line without fill_en is ignored.
        @(negedge clk); new_line = 1'b1; fill_en = 1'b0; #1;
        check("nofill_ready", wr_if.o_wr_ready, 1);
        check("nofill_ram_en", ram_en, 0);
        @(negedge clk); new_line = 1'b0; #1;
        check("nofill_busy", busy, 0);
        check("nofill_ram_en2", ram_en, 0);

        // Fill row 1 at T.
        @(negedge clk); new_line = 1'b1; fill_en = 1'b1; fill_row = 2'd1; #1;
        check("fill_T_ready", wr_if.o_wr_ready, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); new_line = 1'b0; fill_en = 1'b0; #1;
            check("fill_ram_en", ram_en, int'(k <= 8));
            if (k <= 8) begin
                check("fill_ram_we", ram_we, 0);
                check("fill_addr", ram_addr, 8 + k - 1);
            end
            check("fill_lb_we", lb_we, int'(k >= 2 && k <= 9));
            if (k >= 2 && k <= 9) begin
                check("fill_lb_addr", lb_addr, k - 2);
                check("fill_lb_data", lb_data, 8 + k - 2);
                check("fill_lb_bank", lb_bank, 1);
            end
            check("fill_wr_ready", wr_if.o_wr_ready, int'(k == 10));
            check("fill_busy", busy, int'(k <= 9));
        end

        // Host write held across a fill request of row 3.
        @(negedge clk);
        new_line = 1'b1; fill_en = 1'b1; fill_row = 2'd3;
        wr_if.i_wr_valid = 1'b1; wr_if.i_wr_x = 3'd5; wr_if.i_wr_y = 2'd1; wr_if.i_wr_data = 12'h123; #1;
        check("hold_T_ready", wr_if.o_wr_ready, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk); new_line = 1'b0; fill_en = 1'b0; #1;
            check("hold_ready", wr_if.o_wr_ready, int'(k == 10));
            check("hold_ram_we", ram_we, 0);
            if (k == 1) check("hold_fill_addr", ram_addr, 24);
        end
        @(negedge clk); wr_if.i_wr_valid = 1'b0; #1;
        check("hold_wr_we", ram_we, 1);
        check("hold_wr_addr", ram_addr, 13);
        check("hold_wr_data", ram_wdata, 12'h123);

        // Restart during fill: row 1 at T, row 2 at T+4.
        @(negedge clk); new_line = 1'b1; fill_en = 1'b1; fill_row = 2'd1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            new_line = (k == 4); fill_en = (k == 4); fill_row = 2'd2; #1;
            if (k == 4) begin
                check("ur_k4_addr", ram_addr, 11);
                check("ur_k4_underrun", underrun, 0);
            end
            if (k == 5) begin
                check("ur_underrun", underrun, 1);
                check("ur_old_lb_we", lb_we, 1);
                check("ur_old_lb_addr", lb_addr, 3);
                check("ur_old_lb_bank", lb_bank, 1);
                check("ur_old_lb_data", lb_data, 11);
                check("ur_restart_addr", ram_addr, 16);
            end
            if (k == 6) begin
                check("ur_new_lb_addr", lb_addr, 0);
                check("ur_new_lb_bank", lb_bank, 0);
                check("ur_new_lb_data", lb_data, 16);
            end
            if (k == 13) begin
                check("ur_last_lb_addr", lb_addr, 7);
                check("ur_last_lb_data", lb_data, 23);
            end
            check("ur_ready", wr_if.o_wr_ready, int'(k == 14));
            if (k >= 5) check("ur_sticky", underrun, 1);
        end

        // Reset mid-fill: request at T, reset during T+3.
        @(negedge clk); new_line = 1'b1; fill_en = 1'b1; fill_row = 2'd0;
        @(negedge clk); new_line = 1'b0; fill_en = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1; #1;
        check("mr_rst_ready", wr_if.o_wr_ready, 0);
        @(negedge clk); rst = 1'b0; #1;
        check("mr_ram_en", ram_en, 0);
        check("mr_ram_we", ram_we, 0);
        check("mr_lb_we", lb_we, 0);
        check("mr_lb_bank", lb_bank, 0);
        check("mr_underrun", underrun, 0);
        check("mr_busy", busy, 0);
        check("mr_ready", wr_if.o_wr_ready, 1);
        @(negedge clk); #1;
        check("mr_ram_en2", ram_en, 0);
        check("mr_lb_we2", lb_we, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
